note_lane_gen: RTL and testbench

NOTE_LANE_GEN -- requirements
Module: note_lane_gen

---
 rtl/note_lane_gen.sv | 154 +++++++++++++++
 tb/tb_note_lane_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/note_lane_gen.sv
// note_lane_gen: four falling-note lanes for a rhythm game.
// Each lane carries a vertical position (0..479) and a 5-bit drum pattern.
// Notes move only on a qualifying frame tick, by speed+1 pixels per frame.
// Lane 1 starts the cascade. Each later lane wakes up once the lane above
// it has travelled 120 pixels.
// A free-running Galois LFSR supplies the patterns. Each lane takes its
// pattern when it spawns or respawns.
module note_lane_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick_i,
  input  logic        enable_i,
  input  logic        perdio_i,
  input  logic [1:0]  speed_i,
  output logic [9:0]  posL1_o,
  output logic [9:0]  posL2_o,
  output logic [9:0]  posL3_o,
  output logic [9:0]  posL4_o,
  output logic [4:0]  linea1_o,
  output logic [4:0]  linea2_o,
  output logic [4:0]  linea3_o,
  output logic [4:0]  linea4_o,
  output logic [3:0]  active_o,
  output logic [12:0] notes_spawned_o
);

  localparam logic [9:0]  POS_LAST   = 10'd479;
  localparam logic [10:0] POS_LAST11 = 11'd479;
  localparam logic [9:0]  CHAIN_GAP  = 10'd120;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [12:0] CNT_MAX    = 13'd8191;

  logic [15:0] lfsr_q, lfsr_d;
  logic [9:0]  pos_q [4];
  logic [9:0]  pos_d [4];
  logic [4:0]  pat_q [4];
  logic [4:0]  pat_d [4];
  logic [3:0]  act_q, act_d;
  logic [12:0] cnt_q, cnt_d;

  logic [4:0]  slice_raw [4];
  logic [4:0]  slice_pat [4];
  logic [3:0]  spawn;
  logic        advance;
  logic [10:0] step;

  // Patterns come from the current LFSR value. An all-zero pattern is not
  // playable, so it is replaced by 5'b00001.
  assign slice_raw[0] = lfsr_q[4:0];
  assign slice_raw[1] = lfsr_q[9:5];
  assign slice_raw[2] = lfsr_q[14:10];
  assign slice_raw[3] = {lfsr_q[15], lfsr_q[3:0]};

  // Substitute the zero pattern lane by lane.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      slice_pat[k] = (slice_raw[k] == 5'd0) ? 5'd1 : slice_raw[k];
    end
  end

  assign advance = frame_tick_i & enable_i & ~perdio_i;
  assign step    = 11'(speed_i) + 11'd1;

  // Galois shift every cycle. The seed is nonzero and the taps are maximal,
  // so the register never reaches zero.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  // Lane next-state: move, clamp, respawn at the bottom, and cascade spawning.
  always_comb begin
    logic [10:0] sum;
    logic        chain_ok;
    // NOTE: every output of this block gets a default before any branch.
    // A path that leaves a variable unassigned would infer a latch.
    sum      = 11'd0;
    chain_ok = 1'b1;
    act_d    = act_q;
    spawn    = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      pos_d[k] = pos_q[k];
      pat_d[k] = pat_q[k];
    end
    if (advance) begin
      for (int k = 0; k < 4; k++) begin
        if (act_q[k]) begin
          if (pos_q[k] == POS_LAST) begin
            pos_d[k] = 10'd0;
            pat_d[k] = slice_pat[k];
            spawn[k] = 1'b1;
          end else begin
            sum      = {1'b0, pos_q[k]} + step;
            pos_d[k] = (sum > POS_LAST11) ? POS_LAST : sum[9:0];
          end
        end else if (chain_ok) begin
          // A new lane appears at the top and does not move on this frame.
          act_d[k] = 1'b1;
          pos_d[k] = 10'd0;
          pat_d[k] = slice_pat[k];
          spawn[k] = 1'b1;
        end
        // NOTE: chain_ok is a blocking temporary inside the loop. Lane k+1
        // reads the value that lane k just computed on this same advance.
        chain_ok = (pos_d[k] >= CHAIN_GAP);
      end
    end
  end

  // Add this cycle's spawns to the counter, saturating at the maximum.
  always_comb begin
    logic [13:0] total;
    total = {1'b0, cnt_q} + 14'(spawn[0]) + 14'(spawn[1])
          + 14'(spawn[2]) + 14'(spawn[3]);
    cnt_d = (total > {1'b0, CNT_MAX}) ? CNT_MAX : total[12:0];
  end

  // State registers with a synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: the lane arrays are a few flops each, not a RAM. Resetting them
    // is cheap, and their outputs must read zero after reset.
    if (reset) begin
      lfsr_q <= LFSR_SEED;
      act_q  <= 4'b0000;
      cnt_q  <= 13'd0;
      for (int k = 0; k < 4; k++) begin
        pos_q[k] <= 10'd0;
        pat_q[k] <= 5'd0;
      end
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values, independent of statement order.
      lfsr_q <= lfsr_d;
      act_q  <= act_d;
      cnt_q  <= cnt_d;
      for (int k = 0; k < 4; k++) begin
        pos_q[k] <= pos_d[k];
        pat_q[k] <= pat_d[k];
      end
    end
  end

  assign posL1_o         = pos_q[0];
  assign posL2_o         = pos_q[1];
  assign posL3_o         = pos_q[2];
  assign posL4_o         = pos_q[3];
  assign linea1_o        = pat_q[0];
  assign linea2_o        = pat_q[1];
  assign linea3_o        = pat_q[2];
  assign linea4_o        = pat_q[3];
  assign active_o        = act_q;
  assign notes_spawned_o = cnt_q;

endmodule

// File: tb/tb_note_lane_gen.sv
// Scoreboard bench for note_lane_gen.
// The driver applies inputs and steps a behavioural lane model on each edge,
// then queues the expected output snapshot.
// The monitor pops one snapshot per cycle on the falling edge and compares it.
module tb_note_lane_gen;

  typedef struct packed {
    logic [3:0][9:0] pos;
    logic [3:0][4:0] pat;
    logic [3:0]      act;
    logic [12:0]     cnt;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        enable;
  logic        perdio;
  logic [1:0]  speed;
  logic [9:0]  posL1, posL2, posL3, posL4;
  logic [4:0]  linea1, linea2, linea3, linea4;
  logic [3:0]  active;
  logic [12:0] notes_spawned;

  int checks   = 0;
  int failures = 0;

  snap_t exp_q[$];

  // Behavioural model state.
  int          m_pos [4];
  int          m_pat [4];
  bit          m_act [4];
  int          m_cnt;
  logic [15:0] m_lfsr;

  note_lane_gen dut (
    .clk             (clk),
    .reset           (reset),
    .frame_tick_i    (frame_tick),
    .enable_i        (enable),
    .perdio_i        (perdio),
    .speed_i         (speed),
    .posL1_o         (posL1),
    .posL2_o         (posL2),
    .posL3_o         (posL3),
    .posL4_o         (posL4),
    .linea1_o        (linea1),
    .linea2_o        (linea2),
    .linea3_o        (linea3),
    .linea4_o        (linea4),
    .active_o        (active),
    .notes_spawned_o (notes_spawned)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // Pattern for lane k taken from an LFSR value; zero is replaced by 1.
  function automatic int pattern_for(input int k, input logic [15:0] l);
    int p;
    case (k)
      0:       p = int'(l) % 32;
      1:       p = (int'(l) / 32) % 32;
      2:       p = (int'(l) / 1024) % 32;
      default: p = (int'(l[15]) * 16) + (int'(l) % 16);
    endcase
    return (p == 0) ? 1 : p;
  endfunction

  // Model one rising edge using the inputs currently applied.
  task automatic model_edge();
    int spawns;
    int nxt;
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        m_pos[k] = 0; m_pat[k] = 0; m_act[k] = 0;
      end
      m_cnt  = 0;
      m_lfsr = 16'hACE1;
      return;
    end
    if (frame_tick && enable && !perdio) begin
      spawns = 0;
      for (int k = 0; k < 4; k++) begin
        if (m_act[k]) begin
          if (m_pos[k] == 479) begin
            m_pos[k] = 0; m_pat[k] = pattern_for(k, m_lfsr); spawns++;
          end else begin
            nxt = m_pos[k] + int'(speed) + 1;
            m_pos[k] = (nxt > 479) ? 479 : nxt;
          end
        end else if (k == 0 || (m_act[k-1] && m_pos[k-1] >= 120)) begin
          m_act[k] = 1; m_pos[k] = 0; m_pat[k] = pattern_for(k, m_lfsr); spawns++;
        end
      end
      m_cnt = (m_cnt + spawns > 8191) ? 8191 : m_cnt + spawns;
    end
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    for (int k = 0; k < 4; k++) begin
      s.pos[k] = 10'(m_pos[k]);
      s.pat[k] = 5'(m_pat[k]);
      s.act[k] = m_act[k];
    end
    s.cnt = 13'(m_cnt);
    return s;
  endfunction

  // One clock: apply inputs, let the edge happen, queue the expectation.
  task automatic cycle(input bit rst, input bit tick, input bit en, input bit pd, input logic [1:0] spd);
    reset = rst; frame_tick = tick; enable = en; perdio = pd; speed = spd;
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_snap());
    #1;
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    snap_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("posL1", 64'(posL1), 64'(e.pos[0]));
      check("posL2", 64'(posL2), 64'(e.pos[1]));
      check("posL3", 64'(posL3), 64'(e.pos[2]));
      check("posL4", 64'(posL4), 64'(e.pos[3]));
      check("lineas", 64'({linea4, linea3, linea2, linea1}),
            64'({e.pat[3], e.pat[2], e.pat[1], e.pat[0]}));
      check("active", 64'(active), 64'(e.act));
      check("notes_spawned", 64'(notes_spawned), 64'(e.cnt));
      for (int k = 0; k < 4; k++) begin
        if (e.act[k]) check("linea_nonzero", 64'(e.pat[k] != 5'd0 && dut.pat_q[k] != 5'd0), 64'd1);
      end
    end
  end

  initial begin
    int ticks;
    logic [1:0] spd;
    reset = 1'b1; frame_tick = 1'b0; enable = 1'b0; perdio = 1'b0; speed = 2'd0;

    // Reset held while the game is enabled and ticks keep arriving.
    for (int i = 0; i < 6; i++) cycle(1, 1, 1, 0, 2'd0);
    @(negedge clk); #1;
    check("reset_active", 64'(active), 64'd0);
    check("reset_count", 64'(notes_spawned), 64'd0);

    // Slowest speed: 121 ticks put lane 1 at 120 and wake lane 2.
    for (int i = 0; i < 121; i++) cycle(0, 1, 1, 0, 2'd0);
    @(negedge clk); #1;
    check("d_posL1_120", 64'(posL1), 64'd120);
    check("d_active_0011", 64'(active), 64'b0011);
    check("d_posL2_0", 64'(posL2), 64'd0);
    check("d_count_2", 64'(notes_spawned), 64'd2);

    // Game lost for 50 ticks: everything frozen. Then play resumes.
    for (int i = 0; i < 50; i++) cycle(0, 1, 1, 1, 2'd2);
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, 0, 2'd1);

    // Fastest speed long enough for all lanes to be active and wrap around.
    for (int i = 0; i < 400; i++) cycle(0, 1, 1, 0, 2'd3);
    @(negedge clk); #1;
    check("d_all_active", 64'(active), 64'b1111);

    // Reset mid-game, then the first advance restarts lane 1 only.
    cycle(1, 1, 1, 0, 2'd3);
    @(negedge clk); #1;
    check("d_midreset_pos", 64'({posL1, posL2, posL3, posL4}), 64'd0);
    cycle(0, 1, 1, 0, 2'd3);
    @(negedge clk); #1;
    check("d_restart_active", 64'(active), 64'b0001);
    check("d_restart_count", 64'(notes_spawned), 64'd1);

    // Randomised play: 20000 ticks with varying speed, pauses and losses.
    ticks = 0;
    spd = 2'($urandom_range(0, 3));
    while (ticks < 20000) begin
      bit t;
      if ($urandom_range(0, 99) < 5) spd = 2'($urandom_range(0, 3));
      t = ($urandom_range(0, 9) < 6);
      if (t) ticks++;
      cycle(0, t, $urandom_range(0, 19) != 0, $urandom_range(0, 49) == 0, spd);
    end

    @(negedge clk); #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
